// File: rtl/e_mdu_pkg.sv
// Shared MDU opcode encoding for the decoder and the E-stage multiply/divide unit.
package e_mdu_pkg;

   localparam logic [2:0] MDU_OP_NONE  = 3'd0;
   localparam logic [2:0] MDU_OP_MULT  = 3'd1;
   localparam logic [2:0] MDU_OP_MULTU = 3'd2;
   localparam logic [2:0] MDU_OP_DIV   = 3'd3;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd6;
   localparam logic [2:0] MDU_OP_RSVD  = 3'd7;

   function automatic logic mdu_is_mul(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
   endfunction

   function automatic logic mdu_is_div(input logic [2:0] op);
      return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Start/operand bundle from the E stage into the MDU and its HI/LO/busy return.
interface e_mdu_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [2:0]       mdu_op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, mdu_op, src_a, src_b,
      input  busy, hi, lo
   );

   modport slave (
      input  start, mdu_op, src_a, src_b,
      output busy, hi, lo
   );

endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Result is computed at launch; busy only models the issue latency.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic  clk,
   input  logic  reset,
   e_mdu_if.slave bus
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0]    C_MUL = CW'(MULT_CYCLES);
   localparam logic [CW-1:0]    C_DIV = CW'(DIV_CYCLES);
   localparam logic [CW-1:0]    C_ONE = CW'(1);
   localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] W_ONES = '1;

   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;

   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic [WIDTH-1:0]   w_q_s;
   logic [WIDTH-1:0]   w_r_s;
   logic [WIDTH-1:0]   w_q_u;
   logic [WIDTH-1:0]   w_r_u;
   logic               w_b_zero;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   assign w_a = bus.src_a;
   assign w_b = bus.src_b;

   always_comb begin
      w_prod_s = $signed({{WIDTH{w_a[WIDTH-1]}}, w_a}) *
                 $signed({{WIDTH{w_b[WIDTH-1]}}, w_b});
      w_prod_u = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
      w_q_s    = $signed(w_a) / $signed(w_b);
      w_r_s    = $signed(w_a) % $signed(w_b);
      w_q_u    = w_a / w_b;
      w_r_u    = w_a % w_b;
      w_b_zero = (w_b == '0);
      w_ovf    = (w_a == W_MIN) && (w_b == W_ONES);
   end

   // Zero divisor and MIN/-1 are pinned here so no divider corner leaks out.
   always_comb begin
      w_res_hi = '0;
      w_res_lo = '0;
      unique case (bus.mdu_op)
         MDU_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         MDU_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         MDU_OP_DIV: begin
            if (w_b_zero) begin
               w_res_hi = w_a;
               w_res_lo = W_ONES;
            end else if (w_ovf) begin
               w_res_hi = '0;
               w_res_lo = W_MIN;
            end else begin
               w_res_hi = w_r_s;
               w_res_lo = w_q_s;
            end
         end
         MDU_OP_DIVU: begin
            if (w_b_zero) begin
               w_res_hi = w_a;
               w_res_lo = W_ONES;
            end else begin
               w_res_hi = w_r_u;
               w_res_lo = w_q_u;
            end
         end
         default: begin
            w_res_hi = '0;
            w_res_lo = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
      end else if (r_busy) begin
         if (r_cnt == C_ONE) begin
            r_hi   <= r_res_hi;
            r_lo   <= r_res_lo;
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt - C_ONE;
         end
      end else if (bus.start) begin
         if (mdu_is_mul(bus.mdu_op) || mdu_is_div(bus.mdu_op)) begin
            r_res_hi <= w_res_hi;
            r_res_lo <= w_res_lo;
            r_busy   <= 1'b1;
            r_cnt    <= mdu_is_mul(bus.mdu_op) ? C_MUL : C_DIV;
         end else if (bus.mdu_op == MDU_OP_MTHI) begin
            r_hi <= w_a;
         end else if (bus.mdu_op == MDU_OP_MTLO) begin
            r_lo <= w_a;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Randomised checker for e_mdu against an arithmetic HI/LO model,
// at 32-bit default latencies and at 16-bit single-cycle latencies.
module tb_e_mdu;

   logic clk;
   logic reset;

   e_mdu_if #(.WIDTH(32)) ifa ();
   e_mdu_if #(.WIDTH(16)) ifb ();

   e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   int          n_cmp;
   int          n_err;
   int          sel;
   int          w;
   int          mc;
   int          dc;
   logic [31:0] mask;
   logic [31:0] minv;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (w=%0d): got %h, expected %h",
                  tag, w, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (sel == 0) begin
         ifa.start  = s;
         ifa.mdu_op = op;
         ifa.src_a  = a;
         ifa.src_b  = b;
      end else begin
         ifb.start  = s;
         ifb.mdu_op = op;
         ifb.src_a  = a[15:0];
         ifb.src_b  = b[15:0];
      end
   endtask

   function automatic logic [31:0] o_hi();
      return (sel == 0) ? ifa.hi : {16'h0, ifb.hi};
   endfunction

   function automatic logic [31:0] o_lo();
      return (sel == 0) ? ifa.lo : {16'h0, ifb.lo};
   endfunction

   function automatic logic [31:0] o_busy();
      return (sel == 0) ? {31'h0, ifa.busy} : {31'h0, ifb.busy};
   endfunction

   function automatic longint sx(input logic [31:0] v);
      longint r;
      r = longint'({32'h0, v});
      if (v[w-1]) r = r - (longint'(1) <<< w);
      return r;
   endfunction

   task automatic model(input logic [2:0] op,
                        input logic [31:0] ai, input logic [31:0] bi,
                        output logic [31:0] rh, output logic [31:0] rl);
      logic [31:0] a;
      logic [31:0] b;
      longint      sa;
      longint      sb;
      longint      p;
      longint      q;
      longint      r;
      logic [63:0] pu;
      a  = ai & mask;
      b  = bi & mask;
      sa = sx(a);
      sb = sx(b);
      rh = 32'h0;
      rl = 32'h0;
      case (op)
         3'd1: begin
            p  = sa * sb;
            rh = 32'(p >>> w) & mask;
            rl = 32'(p) & mask;
         end
         3'd2: begin
            pu = {32'h0, a} * {32'h0, b};
            rh = 32'(pu >> w) & mask;
            rl = 32'(pu) & mask;
         end
         3'd3: begin
            if (b == 0) begin
               rh = a;
               rl = mask;
            end else if (a == minv && sb == -1) begin
               rh = 32'h0;
               rl = minv;
            end else begin
               q  = sa / sb;
               r  = sa - q * sb;
               rh = 32'(r) & mask;
               rl = 32'(q) & mask;
            end
         end
         3'd4: begin
            if (b == 0) begin
               rh = a;
               rl = mask;
            end else begin
               rh = a % b;
               rl = a / b;
            end
         end
         default: ;
      endcase
   endtask

   task automatic run_md(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit inj);
      logic [31:0] rh;
      logic [31:0] rl;
      int          lat;
      int          ik;
      model(op, a, b, rh, rl);
      lat = (op <= 3'd2) ? mc : dc;
      ik  = (lat > 1) ? 2 : 1;
      drive(1'b1, op, a, b);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      for (int k = 1; k <= lat; k++) begin
         check({tag, "_busy"}, o_busy(), 32'h1);
         check({tag, "_hold_hi"}, o_hi(), m_hi);
         check({tag, "_hold_lo"}, o_lo(), m_lo);
         if (inj && k == ik)
            drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
         step();
         drive(1'b0, 3'd0, 32'h0, 32'h0);
      end
      m_hi = rh;
      m_lo = rl;
      check({tag, "_done"}, o_busy(), 32'h0);
      check({tag, "_hi"}, o_hi(), m_hi);
      check({tag, "_lo"}, o_lo(), m_lo);
   endtask

   task automatic run_mv(input string tag, input logic [2:0] op,
                         input logic [31:0] a);
      drive(1'b1, op, a, $urandom);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      if (op == 3'd5) m_hi = a & mask;
      if (op == 3'd6) m_lo = a & mask;
      check({tag, "_busy"}, o_busy(), 32'h0);
      check({tag, "_hi"}, o_hi(), m_hi);
      check({tag, "_lo"}, o_lo(), m_lo);
      step();
      check({tag, "_busy2"}, o_busy(), 32'h0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      check({tag, "_busy"}, o_busy(), 32'h0);
      check({tag, "_hi"}, o_hi(), 32'h0);
      check({tag, "_lo"}, o_lo(), 32'h0);
   endtask

   task automatic spec_ck(input string tag,
                          input logic [31:0] h, input logic [31:0] l);
      if (sel == 0) begin
         check({tag, "_const_hi"}, o_hi(), h);
         check({tag, "_const_lo"}, o_lo(), l);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return mask;
         3: return minv;
         4: return 32'h2;
         default: return $urandom;
      endcase
   endfunction

   task automatic abort_test();
      int rc;
      rc = (dc >= 4) ? 4 : 1;
      run_mv("ab_mthi", 3'd5, 32'h5A5A5A5A);
      run_mv("ab_mtlo", 3'd6, 32'hA5A5A5A5);
      drive(1'b1, 3'd3, 32'hFFFFFFF9, 32'h2);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      for (int k = 1; k < rc; k++) begin
         check("ab_busy", o_busy(), 32'h1);
         step();
      end
      do_reset("ab_rst");
      for (int k = 0; k < dc + 2; k++) step();
      check("ab_late_busy", o_busy(), 32'h0);
      check("ab_late_hi", o_hi(), 32'h0);
      check("ab_late_lo", o_lo(), 32'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      sel   = 0;
      w     = 32;
      mask  = 32'hFFFFFFFF;
      minv  = 32'h80000000;
      mc    = 5;
      dc    = 10;
      ifa.start = 1'b0; ifa.mdu_op = 3'd0; ifa.src_a = '0; ifa.src_b = '0;
      ifb.start = 1'b0; ifb.mdu_op = 3'd0; ifb.src_a = '0; ifb.src_b = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      for (int s = 0; s < 2; s++) begin
         sel  = s;
         w    = (s == 0) ? 32 : 16;
         mask = (s == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
         minv = 32'h1 << (w - 1);
         mc   = (s == 0) ? 5 : 1;
         dc   = (s == 0) ? 10 : 1;
         do_reset("rst");

         run_md("t1_mult", 3'd1, 32'hFFFFFFFE, 32'h3, 1'b0);
         spec_ck("t1", 32'hFFFFFFFF, 32'hFFFFFFFA);
         run_md("t2_multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
         spec_ck("t2", 32'hFFFFFFFE, 32'h00000001);
         run_md("t3_div", 3'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
         spec_ck("t3", 32'hFFFFFFFF, 32'hFFFFFFFD);
         run_md("t3_divu", 3'd4, 32'hFFFFFFF9, 32'h2, 1'b0);
         spec_ck("t3u", 32'h00000001, 32'h7FFFFFFC);
         run_md("t4_ovf", 3'd3, minv, 32'hFFFFFFFF, 1'b0);
         spec_ck("t4", 32'h0, 32'h80000000);
         run_md("t4_dz", 3'd4, 32'h5, 32'h0, 1'b0);
         spec_ck("t4z", 32'h5, 32'hFFFFFFFF);
         run_md("t4_sdz", 3'd3, 32'hFFFFFFF0, 32'h0, 1'b0);

         drive(1'b1, 3'd1, 32'h7, 32'h9);
         step();
         drive(1'b1, 3'd5, 32'h1234, 32'h0);
         step();
         drive(1'b0, 3'd0, 32'h0, 32'h0);
         for (int k = 0; k < mc; k++) step();
         check("t5_ign_hi", o_hi(), 32'h0);
         check("t5_ign_lo", o_lo(), 32'd63);
         m_hi = 32'h0;
         m_lo = 32'd63;
         run_mv("t5_mtlo", 3'd6, 32'hABCD);
         run_mv("op0", 3'd0, 32'hDEAD);
         run_mv("op7", 3'd7, 32'hBEEF);

         abort_test();

         for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op >= 3'd1 && op <= 3'd4)
               run_md("rnd_md", op, pick(), pick(),
                      ($urandom_range(0, 2) == 0));
            else
               run_mv("rnd_mv", op, $urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
